// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the two ALU requesters and the sharing controller.
// master = requester side, slave = controller side.
interface alu_share_ctrl_if;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_a_0, req_a_1;
  logic [31:0] req_b_0, req_b_1;
  logic [4:0]  req_opcode_0, req_opcode_1;
  logic [4:0]  req_shamt_0, req_shamt_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0, rsp_ready_1;
  logic [31:0] rsp_result;
  logic        rsp_isNotEqual, rsp_isLessThan, rsp_overflow, rsp_err;

  modport master (
    output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
           req_opcode_0, req_opcode_1, req_shamt_0, req_shamt_1,
           rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_result,
           rsp_isNotEqual, rsp_isLessThan, rsp_overflow, rsp_err
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
           req_opcode_0, req_opcode_1, req_shamt_0, req_shamt_1,
           rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_result,
           rsp_isNotEqual, rsp_isLessThan, rsp_overflow, rsp_err
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Shares one 32-bit ALU between two valid/ready ports; one response register, result
// visible the cycle after acceptance, owner backpressure stalls both request ports.
module alu_share_ctrl #(
  parameter bit FAIR = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  alu_share_ctrl_if.slave bus
);
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        ptr_q, ptr_d;
  logic [31:0] result_q, result_d;
  logic        ne_q, ne_d, lt_q, lt_d, ov_q, ov_d, err_q, err_d;

  logic        owner_rdy, drain, can_accept, any_vld, sel, xfer;
  logic [31:0] op_a, op_b, alu_sum, alu_diff, alu_res;
  logic [4:0]  op_code, op_shamt;
  logic        alu_ne, alu_lt, alu_ov, alu_err;

  // Arbitration: a lone valid port wins; on contention FAIR picks ptr, otherwise port 0.
  always_comb begin
    any_vld    = bus.req_valid_0 | bus.req_valid_1;
    if (bus.req_valid_0 && bus.req_valid_1) sel = FAIR ? ptr_q : 1'b0;
    else                                    sel = bus.req_valid_1;
    owner_rdy  = owner_q ? bus.rsp_ready_1 : bus.rsp_ready_0;
    drain      = (state_q == S_FULL) && owner_rdy;
    can_accept = (state_q == S_EMPTY) || drain;
    bus.req_ready_0 = !rst_i && can_accept && any_vld && !sel;
    bus.req_ready_1 = !rst_i && can_accept && any_vld &&  sel;
    xfer       = bus.req_ready_0 | bus.req_ready_1;
  end

  // Operand mux defaults to port 0 when idle; the ALU output is then ignored.
  assign op_a     = sel ? bus.req_a_1      : bus.req_a_0;
  assign op_b     = sel ? bus.req_b_1      : bus.req_b_0;
  assign op_code  = sel ? bus.req_opcode_1 : bus.req_opcode_0;
  assign op_shamt = sel ? bus.req_shamt_1  : bus.req_shamt_0;

  assign alu_sum  = op_a + op_b;
  assign alu_diff = op_a - op_b;

  // Flags leave here already masked to the opcodes that define them.
  always_comb begin
    alu_res = 32'd0;
    alu_ne  = 1'b0;
    alu_lt  = 1'b0;
    alu_ov  = 1'b0;
    alu_err = 1'b0;
    unique case (op_code)
      OP_ADD: begin
        alu_res = alu_sum;
        alu_ov  = (op_a[31] == op_b[31]) && (alu_sum[31] != op_a[31]);
      end
      OP_SUB: begin
        alu_res = alu_diff;
        alu_ov  = (op_a[31] != op_b[31]) && (alu_diff[31] != op_a[31]);
        alu_ne  = (op_a != op_b);
        alu_lt  = ($signed(op_a) < $signed(op_b));
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_SLL:  alu_res = op_a << op_shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> op_shamt);
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    ne_d     = ne_q;
    lt_d     = lt_q;
    ov_d     = ov_q;
    err_d    = err_q;
    if (xfer) begin
      state_d  = S_FULL;
      owner_d  = sel;
      result_d = alu_res;
      ne_d     = alu_ne;
      lt_d     = alu_lt;
      ov_d     = alu_ov;
      err_d    = alu_err;
      if (FAIR) ptr_d = ~sel;
    end else if (drain) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_EMPTY;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      result_q <= 32'd0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
      ov_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
      ne_q     <= ne_d;
      lt_q     <= lt_d;
      ov_q     <= ov_d;
      err_q    <= err_d;
    end
  end

  assign bus.rsp_valid_0    = (state_q == S_FULL) && !owner_q;
  assign bus.rsp_valid_1    = (state_q == S_FULL) &&  owner_q;
  assign bus.rsp_result     = result_q;
  assign bus.rsp_isNotEqual = ne_q;
  assign bus.rsp_isLessThan = lt_q;
  assign bus.rsp_overflow   = ov_q;
  assign bus.rsp_err        = err_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: vector table through a response scoreboard, plus
// hand-written arbitration, backpressure, reset and fixed-priority sequences.
module tb_alu_share_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_ctrl_if bus_f ();
  alu_share_ctrl_if bus_p ();

  alu_share_ctrl #(.FAIR(1'b1)) dut_f (.clk_i(clk), .rst_i(rst), .bus(bus_f.slave));
  alu_share_ctrl #(.FAIR(1'b0)) dut_p (.clk_i(clk), .rst_i(rst), .bus(bus_p.slave));

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    int          port;
    logic [31:0] res;
    logic        ne, lt, ov, err;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] res;
    logic        ne, lt, ov, err;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  int   grants[$];
  vec_t cur0, cur1;
  vec_t tbl[12];

  function automatic vec_t mk(logic [4:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh,
                              int port, logic [31:0] res, logic ne, logic lt, logic ov, logic err);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sh = sh; v.port = port;
    v.res = res; v.ne = ne; v.lt = lt; v.ov = ov; v.err = err;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(int p, vec_t v);
    if (p == 0) begin
      cur0 = v;
      bus_f.req_valid_0 = 1'b1; bus_f.req_a_0 = v.a; bus_f.req_b_0 = v.b;
      bus_f.req_opcode_0 = v.op; bus_f.req_shamt_0 = v.sh;
    end else begin
      cur1 = v;
      bus_f.req_valid_1 = 1'b1; bus_f.req_a_1 = v.a; bus_f.req_b_1 = v.b;
      bus_f.req_opcode_1 = v.op; bus_f.req_shamt_1 = v.sh;
    end
  endtask

  task automatic consume(int p);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL sb_empty: response on port %0d with nothing expected", p);
    end else begin
      e = sb.pop_front();
      chk("rsp_port", p, e.port);
      chk("rsp_result", bus_f.rsp_result, e.res);
      chk("rsp_isNotEqual", {31'd0, bus_f.rsp_isNotEqual}, {31'd0, e.ne});
      chk("rsp_isLessThan", {31'd0, bus_f.rsp_isLessThan}, {31'd0, e.lt});
      chk("rsp_overflow", {31'd0, bus_f.rsp_overflow}, {31'd0, e.ov});
      chk("rsp_err", {31'd0, bus_f.rsp_err}, {31'd0, e.err});
    end
  endtask

  task automatic push(int p, vec_t v);
    exp_t e;
    e.port = p; e.res = v.res; e.ne = v.ne; e.lt = v.lt; e.ov = v.ov; e.err = v.err;
    sb.push_back(e);
    grants.push_back(p);
  endtask

  // Called at a negedge with inputs just set; observes handshakes, then advances one cycle.
  task automatic tick();
    #1;
    chk("ready_exclusive", {31'd0, bus_f.req_ready_0 & bus_f.req_ready_1}, 32'd0);
    if (bus_f.rsp_valid_0 && bus_f.rsp_ready_0) consume(0);
    if (bus_f.rsp_valid_1 && bus_f.rsp_ready_1) consume(1);
    if (bus_f.req_valid_0 && bus_f.req_ready_0) push(0, cur0);
    if (bus_f.req_valid_1 && bus_f.req_ready_1) push(1, cur1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus_f.req_valid_0 = 1'b0; bus_f.req_valid_1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    grants.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_f.req_valid_0 = 0; bus_f.req_valid_1 = 0; bus_f.rsp_ready_0 = 0; bus_f.rsp_ready_1 = 0;
    bus_f.req_a_0 = 0; bus_f.req_b_0 = 0; bus_f.req_opcode_0 = 0; bus_f.req_shamt_0 = 0;
    bus_f.req_a_1 = 0; bus_f.req_b_1 = 0; bus_f.req_opcode_1 = 0; bus_f.req_shamt_1 = 0;
    bus_p.req_valid_0 = 0; bus_p.req_valid_1 = 0; bus_p.rsp_ready_0 = 0; bus_p.rsp_ready_1 = 0;
    bus_p.req_a_0 = 0; bus_p.req_b_0 = 0; bus_p.req_opcode_0 = 0; bus_p.req_shamt_0 = 0;
    bus_p.req_a_1 = 0; bus_p.req_b_1 = 0; bus_p.req_opcode_1 = 0; bus_p.req_shamt_1 = 0;

    tbl[0]  = mk(5'b00000, 32'h7FFFFFFF, 32'h00000001, 5'd0,  0, 32'h80000000, 0, 0, 1, 0);
    tbl[1]  = mk(5'b00001, 32'd5,        32'd7,        5'd0,  1, 32'hFFFFFFFE, 1, 1, 0, 0);
    tbl[2]  = mk(5'b00010, 32'hFFFFFFFF, 32'h0000000F, 5'd0,  0, 32'h0000000F, 0, 0, 0, 0);
    tbl[3]  = mk(5'b00011, 32'h00000F0F, 32'h0000F0F0, 5'd0,  0, 32'h0000FFFF, 0, 0, 0, 0);
    tbl[4]  = mk(5'b00100, 32'h00000001, 32'h00000055, 5'd31, 1, 32'h80000000, 0, 0, 0, 0);
    tbl[5]  = mk(5'b00101, 32'h80000000, 32'h00000000, 5'd4,  0, 32'hF8000000, 0, 0, 0, 0);
    tbl[6]  = mk(5'b00111, 32'h12345678, 32'h12345679, 5'd3,  0, 32'h00000000, 0, 0, 0, 1);
    tbl[7]  = mk(5'b00001, 32'h80000000, 32'h00000001, 5'd0,  1, 32'h7FFFFFFF, 1, 1, 1, 0);
    tbl[8]  = mk(5'b00001, 32'd9,        32'd9,        5'd0,  1, 32'h00000000, 0, 0, 0, 0);
    tbl[9]  = mk(5'b11111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  1, 32'h00000000, 0, 0, 0, 1);
    tbl[10] = mk(5'b00001, 32'd7,        32'd5,        5'd0,  0, 32'h00000002, 1, 0, 0, 0);
    tbl[11] = mk(5'b00000, 32'h00000010, 32'h00000020, 5'd0,  1, 32'h00000030, 0, 0, 0, 0);

    @(negedge clk);
    // Reset state, with requests present that must not be accepted.
    bus_f.req_valid_0 = 1; bus_f.req_valid_1 = 1;
    tick();
    #1;
    chk("rst_req_ready_0", {31'd0, bus_f.req_ready_0}, 32'd0);
    chk("rst_req_ready_1", {31'd0, bus_f.req_ready_1}, 32'd0);
    chk("rst_rsp_valid", {30'd0, bus_f.rsp_valid_1, bus_f.rsp_valid_0}, 32'd0);
    chk("rst_rsp_result", bus_f.rsp_result, 32'd0);
    chk("rst_flags", {28'd0, bus_f.rsp_isNotEqual, bus_f.rsp_isLessThan,
                      bus_f.rsp_overflow, bus_f.rsp_err}, 32'd0);
    idle();
    do_reset();

    // Table: one request at a time, response one cycle later.
    bus_f.rsp_ready_0 = 1; bus_f.rsp_ready_1 = 1;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].port, tbl[i]);
      #1;
      chk("vec_req_ready", {31'd0, tbl[i].port == 0 ? bus_f.req_ready_0 : bus_f.req_ready_1}, 32'd1);
      tick();
      idle();
      #1;
      chk("vec_latency", {30'd0, bus_f.rsp_valid_1, bus_f.rsp_valid_0},
          tbl[i].port == 0 ? 32'd1 : 32'd2);
      tick();
    end
    chk("sb_drained_tbl", sb.size(), 32'd0);

    // Round-robin from reset with both ports continuously valid.
    do_reset();
    bus_f.rsp_ready_0 = 1; bus_f.rsp_ready_1 = 1;
    drive(0, tbl[3]);
    drive(1, mk(5'b00010, 32'hFF, 32'h0F, 5'd0, 1, 32'h0000000F, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++) tick();
    chk("rr_grant_count", grants.size(), 32'd6);
    for (int k = 0; k < 6 && k < grants.size(); k++) chk("rr_grant_order", grants[k], k % 2);

    // Backpressure: last grant was port 1, so port 0 is next.
    bus_f.rsp_ready_0 = 1'b0;
    #1;
    chk("bp_first_grant", {30'd0, bus_f.req_ready_1, bus_f.req_ready_0}, 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_req_ready", {30'd0, bus_f.req_ready_1, bus_f.req_ready_0}, 32'd0);
      chk("bp_rsp_valid_0", {31'd0, bus_f.rsp_valid_0}, 32'd1);
      chk("bp_result_stable", bus_f.rsp_result, 32'h0000FFFF);
      tick();
    end
    bus_f.rsp_ready_0 = 1'b1;
    #1;
    chk("bp_release_drain_and_grant", {30'd0, bus_f.req_ready_1, bus_f.rsp_valid_0}, 32'd3);
    tick();
    idle();
    #1;
    chk("bp_owner_moves", {30'd0, bus_f.rsp_valid_1, bus_f.rsp_valid_0}, 32'd2);
    tick();
    chk("sb_drained_bp", sb.size(), 32'd0);

    // Reset while FULL with owner 1, response held.
    bus_f.rsp_ready_1 = 1'b0;
    drive(1, tbl[1]);
    tick();
    drive(0, tbl[2]);
    rst = 1'b1;
    #1;
    chk("rst_mid_no_accept", {30'd0, bus_f.req_ready_1, bus_f.req_ready_0}, 32'd0);
    tick();
    rst = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_rsp_valid", {30'd0, bus_f.rsp_valid_1, bus_f.rsp_valid_0}, 32'd0);
    chk("rst_mid_result", bus_f.rsp_result, 32'd0);
    bus_f.rsp_ready_1 = 1'b1;
    #1;
    chk("rst_mid_ptr_port0", {30'd0, bus_f.req_ready_1, bus_f.req_ready_0}, 32'd1);
    tick();
    idle();
    tick();
    chk("sb_drained_rst", sb.size(), 32'd0);

    // Fixed priority: port 0 wins every cycle.
    bus_p.rsp_ready_0 = 1; bus_p.rsp_ready_1 = 1;
    bus_p.req_valid_0 = 1; bus_p.req_valid_1 = 1;
    bus_p.req_opcode_0 = 5'b00011; bus_p.req_a_0 = 32'h0F0F; bus_p.req_b_0 = 32'hF0F0;
    bus_p.req_opcode_1 = 5'b00010; bus_p.req_a_1 = 32'hFF;   bus_p.req_b_1 = 32'h0F;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fp_grant", {30'd0, bus_p.req_ready_1, bus_p.req_ready_0}, 32'd1);
      if (k > 0) begin
        chk("fp_rsp_valid", {30'd0, bus_p.rsp_valid_1, bus_p.rsp_valid_0}, 32'd1);
        chk("fp_result", bus_p.rsp_result, 32'h0000FFFF);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
